// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: round-robin arbitration of writeback
// sources into a one-cycle registered write stage, plus a RAW busy scoreboard.
module rf_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [N_REQ*XLEN-1:0]      req_data_i,
  output logic                       rf_we_o,
  output logic [ADDR_W-1:0]          rf_waddr_o,
  output logic [XLEN-1:0]            rf_wdata_o,
  input  logic                       mark_valid_i,
  input  logic [ADDR_W-1:0]          mark_addr_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          rs1_addr_i,
  input  logic [ADDR_W-1:0]          rs2_addr_i,
  output logic                       rs1_busy_o,
  output logic                       rs2_busy_o,
  output logic [31:0]                busy_vec_o
);

  localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR       = N_REQ;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [31:0]       busy_q, busy_d;

  logic              found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  idx;
  logic [N_REQ-1:0]  grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  // Search begins one past the last winner so every source is reached within N_REQ grants.
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr_q;
    idx       = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % NR);
      if (!found && req_valid_i[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant    = '0;
    xfer     = found && rst_ni;
    sel_addr = '0;
    sel_data = '0;
    if (xfer) grant[grant_idx] = 1'b1;
    for (int unsigned i = 0; i < NR; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data = req_data_i[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d   = xfer ? grant_idx : ptr_q;
    we_d    = xfer && (sel_addr != '0);
    waddr_d = xfer ? sel_addr : waddr_q;
    wdata_d = xfer ? sel_data : wdata_q;
  end

  // Order matters: flush, then commit-clear, then mark, so a same-edge mark always survives.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) busy_d = '0;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (mark_valid_i && (mark_addr_i != '0)) busy_d[mark_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q   <= PTR_INIT;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready_o = grant;
  assign rf_we_o     = we_q;
  assign rf_waddr_o  = waddr_q;
  assign rf_wdata_o  = wdata_q;
  assign busy_vec_o  = busy_q;
  assign rs1_busy_o  = busy_q[rs1_addr_i];
  assign rs2_busy_o  = busy_q[rs2_addr_i];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected RF writes are queued at grant
// time and matched against rf_we_o/rf_waddr_o/rf_wdata_o as they appear.
module tb_rf_wb_arbiter;

  localparam int N_REQ  = 3;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*XLEN-1:0]   req_data;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    mark_valid;
  logic [ADDR_W-1:0]       mark_addr;
  logic                    flush;
  logic [ADDR_W-1:0]       rs1_addr;
  logic [ADDR_W-1:0]       rs2_addr;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic [31:0]             busy_vec;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+XLEN-1:0] exp_q[$];

  rf_wb_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .mark_valid_i(mark_valid), .mark_addr_i(mark_addr), .flush_i(flush),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .busy_vec_o(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    req_addr[s*ADDR_W +: ADDR_W] = a;
    req_data[s*XLEN +: XLEN]     = d;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Every RF write seen must be the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_unexpected: got addr %0h data %0h expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [ADDR_W+XLEN-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({rf_waddr, rf_wdata} === e) else begin
          errors++;
          $error("FAIL wr_seq: got %0h/%0h expected %0h/%0h",
                 rf_waddr, rf_wdata, e[ADDR_W+XLEN-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = '1; req_addr = '0; req_data = '0;
    mark_valid = 1'b0; mark_addr = '0; flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
    for (int s = 0; s < N_REQ; s++) set_src(s, ADDR_W'(s + 1), 32'hA000_0000 + 32'(s));

    // Reset with all sources requesting
    step(); step();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_busy", 64'(busy_vec), 64'h0);
    chk("rst_waddr", 64'(rf_waddr), 64'h0);
    rst_n = 1'b1;

    // Round-robin: grants 0,1,2,0,1,2
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'(1 << (c % 3)));
      push_exp(ADDR_W'((c % 3) + 1), 32'hA000_0000 + 32'(c % 3));
      step();
    end
    req_valid = '0;
    #1;
    chk("idle_ready", 64'(req_ready), 64'h0);
    step();
    chk("idle_we", 64'(rf_we), 64'h0);

    // Single source latency
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    chk("single_grant", 64'(req_ready), 64'h2);
    push_exp(5'd5, 32'hDEAD_BEEF);
    step();
    req_valid = '0;
    chk("single_we", 64'(rf_we), 64'h1);
    chk("single_waddr", 64'(rf_waddr), 64'h5);
    chk("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    step();
    chk("single_we_off", 64'(rf_we), 64'h0);
    chk("hold_waddr", 64'(rf_waddr), 64'h5);

    // Scoreboard lifecycle on x7
    mark_valid = 1'b1; mark_addr = 5'd7; rs1_addr = 5'd7;
    #1;
    chk("sb_pre", 64'(rs1_busy), 64'h0);
    step();
    mark_valid = 1'b0;
    chk("sb_set", 64'(rs1_busy), 64'h1);
    chk("sb_vec7", 64'(busy_vec), 64'h80);
    set_src(0, 5'd7, 32'h0000_0077);
    req_valid = 3'b001;
    #1;
    chk("sb_grant", 64'(req_ready), 64'h1);
    push_exp(5'd7, 32'h0000_0077);
    step();
    req_valid = '0;
    chk("sb_busy_t1", 64'(rs1_busy), 64'h1);
    step();
    chk("sb_busy_t2", 64'(rs1_busy), 64'h0);

    // Same-edge commit and mark of x9
    mark_valid = 1'b1; mark_addr = 5'd9;
    step();
    mark_valid = 1'b0;
    chk("x9_set", 64'(busy_vec), 64'h200);
    set_src(2, 5'd9, 32'h0000_0099);
    req_valid = 3'b100;
    #1;
    chk("x9_grant", 64'(req_ready), 64'h4);
    push_exp(5'd9, 32'h0000_0099);
    step();
    req_valid = '0;
    mark_valid = 1'b1; mark_addr = 5'd9;
    step();
    mark_valid = 1'b0;
    chk("x9_set_wins", 64'(busy_vec), 64'h200);
    rs2_addr = 5'd9;
    #1;
    chk("rs2_x9", 64'(rs2_busy), 64'h1);

    // Flush with concurrent mark of x4
    flush = 1'b1; mark_valid = 1'b1; mark_addr = 5'd4;
    step();
    flush = 1'b0; mark_valid = 1'b0;
    chk("flush_vec", 64'(busy_vec), 64'h10);
    rs2_addr = 5'd4; rs1_addr = 5'd0;
    #1;
    chk("rs2_x4", 64'(rs2_busy), 64'h1);
    chk("rs1_x0", 64'(rs1_busy), 64'h0);

    // x0: mark and write to register 0
    mark_valid = 1'b1; mark_addr = 5'd0;
    set_src(1, 5'd0, 32'h0000_0123);
    req_valid = 3'b010;
    #1;
    chk("x0_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0; mark_valid = 1'b0;
    chk("x0_we", 64'(rf_we), 64'h0);
    chk("x0_vec", 64'(busy_vec), 64'h10);

    // Reset drops a staged write and restores the pointer
    set_src(0, 5'd3, 32'h0000_0033);
    req_valid = 3'b001;
    #1;
    chk("pre_rst_grant", 64'(req_ready), 64'h1);
    push_exp(5'd3, 32'h0000_0033);
    step();
    req_valid = '0; rst_n = 1'b0;
    step();
    chk("rst2_we", 64'(rf_we), 64'h0);
    chk("rst2_wdata", 64'(rf_wdata), 64'h0);
    chk("rst2_busy", 64'(busy_vec), 64'h0);
    rst_n = 1'b1;
    req_valid = '1;
    #1;
    chk("rst2_ptr", 64'(req_ready), 64'h1);
    req_valid = '0;
    step(); step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-port controller for the 32x32 register file. It shares the single RF write port between N_REQ writeback sources (ALU, LSU, CSR/mul) using round-robin arbitration and a one-cycle registered write stage. It also keeps a busy scoreboard of destination registers so the issue stage can stall on RAW hazards. It sits between the execute/writeback units and the register file's write_enable/write_addr/write_data inputs.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width of write data
ADDR_W, 5, register address width (32 registers)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  N_REQ  writeback request per source
req_ready_o  out  N_REQ  grant/accept per source (one-hot or zero)
req_addr_i  in  N_REQ*ADDR_W  packed rd per source, source i at [i*ADDR_W +: ADDR_W]
req_data_i  in  N_REQ*XLEN  packed data per source, source i at [i*XLEN +: XLEN]
rf_we_o  out  1  to RF write_enable
rf_waddr_o  out  ADDR_W  to RF write_addr
rf_wdata_o  out  XLEN  to RF write_data
mark_valid_i  in  1  issue stage reserves a destination register
mark_addr_i  in  ADDR_W  register being reserved
flush_i  in  1  clear all reservations (pipeline flush)
rs1_addr_i  in  ADDR_W  hazard query 1
rs2_addr_i  in  ADDR_W  hazard query 2
rs1_busy_o  out  1  rs1 has a pending write
rs2_busy_o  out  1  rs2 has a pending write
busy_vec_o  out  32  full scoreboard, bit 0 always 0

Behaviour:
- Reset (rst_ni=0 at a rising edge): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, all busy bits 0, RR pointer=N_REQ-1 so source 0 has top priority first. A staged write in flight is dropped. req_ready_o is 0 while rst_ni=0.
- Arbitration (combinational): search starts at index pointer+1 mod N_REQ and wraps. The first source with req_valid_i=1 gets req_ready_o=1. At most one grant per cycle. Grant does not depend on any other ready signal, because the RF always accepts.
- Handshake: a transfer happens when valid&ready at a rising edge. After a transfer, the pointer becomes the granted index. With no transfer, the pointer holds. A source must hold addr/data stable while valid is high and not yet granted.
- Write stage: a transfer at edge T loads rf_waddr_o/rf_wdata_o, and rf_we_o=1 during cycle T..T+1, so the RF commits at edge T+1. Latency from grant to RF commit is 1 cycle. With no transfer, rf_we_o=0 next cycle and addr/data hold their last values.
- x0: a request with addr=0 is still granted and consumed, but rf_we_o stays 0 for it.
- Scoreboard set: at an edge with mark_valid_i=1 and mark_addr_i!=0, busy[mark_addr_i]<=1.
- Scoreboard clear: busy[rf_waddr_o]<=0 at the edge where rf_we_o=1 (the RF commit edge). busy therefore falls in the cycle the RF read already returns the new value. There is no bypass.
- Set and clear of the same address at the same edge: set wins, because the newer producer is reserved.
- flush_i=1: all busy bits cleared at the edge. A mark in the same cycle still sets its bit. A staged write still commits.
- Marking an already-busy register leaves it set. WAW is not counted; the first commit clears it. The issuer must not issue a second writer to a busy rd.
- rs1_busy_o/rs2_busy_o = busy[rs*_addr_i], combinational from the registered scoreboard. Address 0 always gives 0.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles with all valids=1 -> req_ready_o=0, rf_we_o=0, busy_vec_o=0. On release, the first grant goes to source 0.
- Round-robin fairness: sources 0,1,2 hold valid for 6 cycles with addrs 1/2/3 -> grants 0,1,2,0,1,2; rf_waddr_o sequence 1,2,3,1,2,3, each one cycle after its grant.
- Single source latency: only source 1 valid with addr=5, data=0xDEADBEEF at edge T -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF in cycle after T; rf_we_o=0 the next cycle.
- Scoreboard lifecycle: mark addr 7, query rs1=7 -> rs1_busy_o=1 from next cycle. A source 0 write to 7 is granted at T -> busy stays 1 in cycle T+1 and reads 0 in cycle T+2.
- Same-edge set/clear and flush: commit to x9 coincides with mark of x9 -> busy[9] stays 1. Then flush_i with mark x4 -> busy_vec_o=0x0000_0010.
- x0 handling: mark addr 0 and write to addr 0 -> busy_vec_o[0]=0, request granted, rf_we_o=0.
